// File: rtl/reg_native_if_pkg.sv
// reg_native_if_pkg: shared FSM state type and default error read data for reg_native_if stages.
package reg_native_if_pkg;
  typedef enum logic [1:0] {IDLE, WAIT, DRAIN} guard_state_e;
  localparam logic [31:0] REG_NATIVE_ERR_RD_DATA = 32'hDEAD_BEEF;
endpackage

// File: rtl/reg_native_if_timeout_guard.sv
// reg_native_if_timeout_guard: single-outstanding request stage that errors out hung IP transactions.
// Optional REG_NATIVE_TIMEOUT_STAT_EN adds a saturating timeout counter output tmo_cnt.
module reg_native_if_timeout_guard
  import reg_native_if_pkg::*;
#(
  parameter int BUS_DATA_WIDTH = 32,
  parameter int BUS_ADDR_WIDTH = 64,
  parameter int TIMEOUT_CYCLES = 256,
  parameter logic [BUS_DATA_WIDTH-1:0] ERR_RD_DATA = BUS_DATA_WIDTH'(REG_NATIVE_ERR_RD_DATA)
) (
  input  logic                      native_clk,
  input  logic                      native_rst,
  input  logic                      req_vld,
  input  logic [BUS_ADDR_WIDTH-1:0] addr,
  input  logic                      wr_en,
  input  logic                      rd_en,
  input  logic [BUS_DATA_WIDTH-1:0] wr_data,
  output logic                      ack_vld,
  output logic                      err,
  output logic [BUS_DATA_WIDTH-1:0] rd_data,
  output logic                      proto_err,
  output logic                      ext_req_vld,
  output logic [BUS_ADDR_WIDTH-1:0] ext_addr,
  output logic                      ext_wr_en,
  output logic                      ext_rd_en,
  output logic [BUS_DATA_WIDTH-1:0] ext_wr_data,
  input  logic                      ext_ack_vld,
  input  logic                      ext_err,
  input  logic [BUS_DATA_WIDTH-1:0] ext_rd_data
`ifdef REG_NATIVE_TIMEOUT_STAT_EN
  ,
  output logic [15:0]               tmo_cnt
`endif
);
  localparam int CW = $clog2(TIMEOUT_CYCLES);
  guard_state_e state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic tmo_hit, accept, fwd_ack, tmo_ack, drain_err, proto_nxt;
  assign tmo_hit = cnt == CW'(TIMEOUT_CYCLES - 1);
  always_ff @(posedge native_clk) begin
    if (native_rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end
  // A coincident ack always beats the timeout in WAIT.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt + 1'b1;
    accept    = 1'b0;
    fwd_ack   = 1'b0;
    tmo_ack   = 1'b0;
    drain_err = 1'b0;
    proto_nxt = 1'b0;
    case (state)
      IDLE: begin
        cnt_nxt   = '0;
        accept    = req_vld;
        state_nxt = req_vld ? WAIT : IDLE;
      end
      WAIT: begin
        proto_nxt = req_vld;
        fwd_ack   = ext_ack_vld;
        tmo_ack   = !ext_ack_vld && tmo_hit;
        state_nxt = ext_ack_vld ? IDLE : tmo_hit ? DRAIN : WAIT;
        cnt_nxt   = (ext_ack_vld || tmo_hit) ? '0 : cnt_nxt;
      end
      DRAIN: begin
        drain_err = req_vld;
        state_nxt = (ext_ack_vld || tmo_hit) ? IDLE : DRAIN;
        cnt_nxt   = (ext_ack_vld || tmo_hit) ? '0 : cnt_nxt;
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end
  always_ff @(posedge native_clk) begin
    if (native_rst) begin
      ack_vld     <= 1'b0;
      err         <= 1'b0;
      rd_data     <= '0;
      proto_err   <= 1'b0;
      ext_req_vld <= 1'b0;
      ext_addr    <= '0;
      ext_wr_en   <= 1'b0;
      ext_rd_en   <= 1'b0;
      ext_wr_data <= '0;
    end else begin
      ack_vld     <= fwd_ack | tmo_ack | drain_err;
      err         <= fwd_ack ? ext_err : (tmo_ack | drain_err) ? 1'b1 : err;
      rd_data     <= fwd_ack ? ext_rd_data : (tmo_ack | drain_err) ? ERR_RD_DATA : rd_data;
      proto_err   <= proto_nxt;
      ext_req_vld <= accept;
      if (accept) begin
        ext_addr    <= addr;
        ext_wr_en   <= wr_en;
        ext_rd_en   <= rd_en;
        ext_wr_data <= wr_data;
      end
    end
  end
`ifdef REG_NATIVE_TIMEOUT_STAT_EN
  always_ff @(posedge native_clk) begin
    if (native_rst) tmo_cnt <= '0;
    else if (tmo_ack && tmo_cnt != 16'hFFFF) tmo_cnt <= tmo_cnt + 16'd1;
  end
`endif
endmodule

// File: tb/tb_reg_native_if_timeout_guard.sv
// tb_reg_native_if_timeout_guard: scenario tasks plus an upstream-ack scoreboard for the timeout guard.
module tb_reg_native_if_timeout_guard;
  localparam logic [31:0] ERR = 32'hDEAD_BEEF;
  logic clk = 1'b0, rst = 1'b1;
  logic req_vld = 0, wr_en = 0, rd_en = 0, ext_ack_vld = 0, ext_err = 0;
  logic [63:0] addr = '0;
  logic [31:0] wr_data = '0, ext_rd_data = '0;
  logic ack_vld, err, proto_err, ext_req_vld, ext_wr_en, ext_rd_en;
  logic [31:0] rd_data, ext_wr_data;
  logic [63:0] ext_addr;
`ifdef REG_NATIVE_TIMEOUT_STAT_EN
  logic [15:0] tmo_cnt;
`endif
  int total = 0, bad = 0;
  logic [32:0] exp_q[$];
  always #5 clk = ~clk;
  reg_native_if_timeout_guard #(.BUS_DATA_WIDTH(32), .BUS_ADDR_WIDTH(64), .TIMEOUT_CYCLES(8)) dut (
    .native_clk(clk), .native_rst(rst), .req_vld(req_vld), .addr(addr), .wr_en(wr_en), .rd_en(rd_en),
    .wr_data(wr_data), .ack_vld(ack_vld), .err(err), .rd_data(rd_data), .proto_err(proto_err),
    .ext_req_vld(ext_req_vld), .ext_addr(ext_addr), .ext_wr_en(ext_wr_en), .ext_rd_en(ext_rd_en),
    .ext_wr_data(ext_wr_data), .ext_ack_vld(ext_ack_vld), .ext_err(ext_err), .ext_rd_data(ext_rd_data)
`ifdef REG_NATIVE_TIMEOUT_STAT_EN
    , .tmo_cnt(tmo_cnt)
`endif
  );
  always @(negedge clk) begin
    if (ack_vld === 1'b1) begin
      logic [32:0] e;
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL sb_unexpected_ack got err=%b rd=%h required no ack", err, rd_data);
      end else begin
        e = exp_q.pop_front();
        if ({err, rd_data} !== e) begin
          bad++;
          $display("FAIL sb_ack_payload got err=%b rd=%h required err=%b rd=%h", err, rd_data, e[32], e[31:0]);
        end
      end
    end
  end
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic issue(input logic [63:0] a, input logic w, input logic [31:0] d);
    req_vld = 1; addr = a; wr_en = w; rd_en = !w; wr_data = d;
    tick();
    req_vld = 0; wr_en = 0; rd_en = 0;
  endtask
  task automatic ext_ack(input logic e, input logic [31:0] d, input logic expect_fwd);
    ext_ack_vld = 1; ext_err = e; ext_rd_data = d;
    if (expect_fwd) exp_q.push_back({e, d});
    tick();
    ext_ack_vld = 0;
  endtask
  task automatic test_reset;
    rst = 1;
    repeat (3) tick();
    total++;
    if ({ack_vld, err, rd_data, proto_err} !== '0) begin
      bad++;
      $display("FAIL reset_up got %b%b %h %b required zeros", ack_vld, err, rd_data, proto_err);
    end
    total++;
    if ({ext_req_vld, ext_addr, ext_wr_en, ext_rd_en, ext_wr_data} !== '0) begin
      bad++;
      $display("FAIL reset_ext got %b %h %b%b %h required zeros", ext_req_vld, ext_addr, ext_wr_en, ext_rd_en, ext_wr_data);
    end
    rst = 0;
  endtask
  task automatic test_read;
    issue(64'h100, 0, 32'h0);
    total++;
    if ({ext_req_vld, ext_addr, ext_wr_en, ext_rd_en} !== {1'b1, 64'h100, 1'b0, 1'b1}) begin
      bad++;
      $display("FAIL read_fwd got %b %h %b%b required 1 100 01", ext_req_vld, ext_addr, ext_wr_en, ext_rd_en);
    end
    tick();
    total++;
    if (ext_req_vld !== 1'b0) begin bad++; $display("FAIL read_req_pulse got %b required 0", ext_req_vld); end
    tick();
    ext_ack(0, 32'h1234, 1);
    total++;
    if (ack_vld !== 1'b1) begin bad++; $display("FAIL read_ack_time got %b required 1", ack_vld); end
  endtask
  task automatic test_timeout;
    issue(64'h200, 1, 32'hA5A5);
    exp_q.push_back({1'b1, ERR});
    total++;
    if ({ext_req_vld, ext_wr_en, ext_wr_data} !== {1'b1, 1'b1, 32'hA5A5}) begin
      bad++;
      $display("FAIL tmo_fwd got %b %b %h required 1 1 0000a5a5", ext_req_vld, ext_wr_en, ext_wr_data);
    end
    for (int k = 1; k < 9; k++) begin
      total++;
      if (ack_vld !== 1'b0) begin bad++; $display("FAIL tmo_early_ack cycle %0d got %b required 0", k, ack_vld); end
      tick();
    end
    total++;
    if (ack_vld !== 1'b1) begin bad++; $display("FAIL tmo_ack_time got %b required 1", ack_vld); end
    repeat (3) tick();
    ext_ack(0, 32'h5555, 0);
    total++;
    if ({ack_vld, err, rd_data} !== {1'b0, 1'b1, ERR}) begin
      bad++;
      $display("FAIL tmo_swallow got %b %b %h required 0 1 deadbeef", ack_vld, err, rd_data);
    end
  endtask
  task automatic test_ack_at_timeout;
    issue(64'h180, 0, 32'h0);
    repeat (7) tick();
    ext_ack(0, 32'hCAFE, 1);
    total++;
    if (ack_vld !== 1'b1) begin bad++; $display("FAIL edge_ack_time got %b required 1", ack_vld); end
    issue(64'h1C0, 1, 32'h11);
    total++;
    if ({ext_req_vld, ext_addr, ext_wr_data} !== {1'b1, 64'h1C0, 32'h11}) begin
      bad++;
      $display("FAIL edge_no_drain got %b %h %h required 1 1c0 00000011", ext_req_vld, ext_addr, ext_wr_data);
    end
    tick();
    ext_ack(1, 32'h77, 1);
    total++;
    if (ack_vld !== 1'b1) begin bad++; $display("FAIL edge_ext_err_ack got %b required 1", ack_vld); end
  endtask
  task automatic test_proto_err;
    issue(64'h200, 0, 32'h0);
    tick();
    req_vld = 1; wr_en = 1; addr = 64'h300; wr_data = 32'hFF;
    tick();
    req_vld = 0; wr_en = 0;
    total++;
    if ({proto_err, ext_req_vld, ext_addr} !== {1'b1, 1'b0, 64'h200}) begin
      bad++;
      $display("FAIL proto_pulse got %b %b %h required 1 0 200", proto_err, ext_req_vld, ext_addr);
    end
    tick();
    total++;
    if (proto_err !== 1'b0) begin bad++; $display("FAIL proto_width got %b required 0", proto_err); end
    ext_ack(0, 32'h4242, 1);
    total++;
    if (ack_vld !== 1'b1) begin bad++; $display("FAIL proto_complete got %b required 1", ack_vld); end
  endtask
  task automatic test_drain;
    issue(64'h400, 1, 32'h1);
    exp_q.push_back({1'b1, ERR});
    repeat (8) tick();
    total++;
    if (ack_vld !== 1'b1) begin bad++; $display("FAIL drain_tmo got %b required 1", ack_vld); end
    tick();
    exp_q.push_back({1'b1, ERR});
    issue(64'h500, 1, 32'h2);
    total++;
    if ({ack_vld, ext_req_vld} !== 2'b10) begin
      bad++;
      $display("FAIL drain_req_err got ack=%b ext_req=%b required ack=1 ext_req=0", ack_vld, ext_req_vld);
    end
    repeat (5) tick();
    exp_q.push_back({1'b1, ERR});
    issue(64'h580, 0, 32'h0);
    total++;
    if ({ack_vld, ext_req_vld, proto_err} !== 3'b100) begin
      bad++;
      $display("FAIL drain_last_cycle got ack=%b ext_req=%b proto=%b required 1 0 0", ack_vld, ext_req_vld, proto_err);
    end
    issue(64'h600, 0, 32'h0);
    total++;
    if ({ext_req_vld, ext_addr} !== {1'b1, 64'h600}) begin
      bad++;
      $display("FAIL drain_exit got %b %h required 1 600", ext_req_vld, ext_addr);
    end
    tick();
    ext_ack(0, 32'h99, 1);
    total++;
    if (ack_vld !== 1'b1) begin bad++; $display("FAIL drain_after got %b required 1", ack_vld); end
  endtask
  task automatic test_reset_mid;
`ifdef REG_NATIVE_TIMEOUT_STAT_EN
    total++;
    if (tmo_cnt !== 16'd2) begin bad++; $display("FAIL stat_count got %0d required 2", tmo_cnt); end
`endif
    issue(64'h700, 0, 32'h0);
    tick();
    rst = 1;
    repeat (2) tick();
    rst = 0;
    total++;
    if ({ack_vld, err, rd_data, proto_err, ext_req_vld, ext_addr, ext_wr_en, ext_rd_en, ext_wr_data} !== '0) begin
      bad++;
      $display("FAIL mid_reset got %b%b %h %b %b %h %b%b %h required zeros", ack_vld, err, rd_data, proto_err,
               ext_req_vld, ext_addr, ext_wr_en, ext_rd_en, ext_wr_data);
    end
`ifdef REG_NATIVE_TIMEOUT_STAT_EN
    total++;
    if (tmo_cnt !== 16'd0) begin bad++; $display("FAIL stat_clear got %0d required 0", tmo_cnt); end
`endif
    ext_ack(0, 32'hBAD, 0);
    total++;
    if (ack_vld !== 1'b0) begin bad++; $display("FAIL mid_late_ack got %b required 0", ack_vld); end
    issue(64'h800, 0, 32'h0);
    total++;
    if ({ext_req_vld, ext_addr} !== {1'b1, 64'h800}) begin
      bad++;
      $display("FAIL mid_idle got %b %h required 1 800", ext_req_vld, ext_addr);
    end
    ext_ack(0, 32'h8888, 1);
    tick();
  endtask
  initial begin
    test_reset();
    test_read();
    test_timeout();
    test_ack_at_timeout();
    test_proto_err();
    test_drain();
    test_reset_mid();
    repeat (2) tick();
    total++;
    if (exp_q.size() != 0) begin bad++; $display("FAIL sb_leftover got %0d required 0", exp_q.size()); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
